// File: rtl/parallel_carry_adder_16bit_if.sv
// Operand/result bundle for the 16-bit lookahead adder: the master drives the operands
// and the slave returns both the combinational and the registered results.
interface parallel_carry_adder_16bit_if;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
    logic [15:0] sum;
    logic        c_out;
    logic        ovf;
    logic [15:0] sum_q;
    logic        c_out_q;
    logic        ovf_q;

    modport master (
        output a, b, c_in,
        input  sum, c_out, ovf, sum_q, c_out_q, ovf_q
    );

    modport slave (
        input  a, b, c_in,
        output sum, c_out, ovf, sum_q, c_out_q, ovf_q
    );
endinterface

// File: rtl/parallel_carry_adder_16bit.sv
// 16-bit two-level carry-lookahead adder (four 4-bit groups) with a signed overflow flag.
// sum/c_out/ovf are combinational; *_q copies lag one clk; there is no stall path, inputs are taken every cycle.
module parallel_carry_adder_16bit (
    input  logic                          clk,
    input  logic                          rst,
    parallel_carry_adder_16bit_if.slave   bus
);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [3:0]  gc;
    logic        c16;
    logic [15:0] sum_d;
    logic        c_out_d;
    logic        ovf_d;
    logic [15:0] sum_q;
    logic        c_out_q;
    logic        ovf_q;

    always_comb begin
        g   = bus.a & bus.b;
        p   = bus.a ^ bus.b;
        gg  = '0;
        gp  = '0;
        c   = '0;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end

        // Every group carry is a flat sum-of-products from c_in, so no group waits on another.
        gc[0] = bus.c_in;
        gc[1] = gg[0] | (gp[0] & bus.c_in);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & bus.c_in);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & bus.c_in);
        c16   = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & bus.c_in);

        for (int k = 0; k < 4; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
        end

        sum_d   = p ^ c;
        c_out_d = c16;
        ovf_d   = c[15] ^ c16;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.sum     = sum_d;
    assign bus.c_out   = c_out_d;
    assign bus.ovf     = ovf_d;
    assign bus.sum_q   = sum_q;
    assign bus.c_out_q = c_out_q;
    assign bus.ovf_q   = ovf_q;
endmodule

// File: tb/tb_parallel_carry_adder_16bit.sv
// Directed and swept vectors for the 16-bit lookahead adder, checking combinational and registered results.
module tb_parallel_carry_adder_16bit;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    parallel_carry_adder_16bit_if pif ();

    parallel_carry_adder_16bit dut (
        .clk (clk),
        .rst (rst),
        .bus (pif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive between edges, check the combinational result, then the registered copy after one edge.
    task automatic apply(input string tag, input logic [15:0] a, input logic [15:0] b, input logic ci,
                         input logic [15:0] es, input logic ec, input logic eo);
        @(negedge clk);
        pif.a    = a;
        pif.b    = b;
        pif.c_in = ci;
        #1;
        check({tag, ".sum"},   32'(pif.sum),   32'(es));
        check({tag, ".c_out"}, 32'(pif.c_out), 32'(ec));
        check({tag, ".ovf"},   32'(pif.ovf),   32'(eo));
        @(posedge clk);
        #1;
        check({tag, ".sum_q"},   32'(pif.sum_q),   32'(es));
        check({tag, ".c_out_q"}, 32'(pif.c_out_q), 32'(ec));
        check({tag, ".ovf_q"},   32'(pif.ovf_q),   32'(eo));
    endtask

    // Reference built from a plain 17-bit add and the sign rule.
    task automatic apply_model(input string tag, input logic [15:0] a, input logic [15:0] b, input logic ci);
        logic [16:0] full;
        logic        eo;
        full = {1'b0, a} + {1'b0, b} + {16'd0, ci};
        eo   = (a[15] == b[15]) && (full[15] != a[15]);
        apply(tag, a, b, ci, full[15:0], full[16], eo);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b1;
        pif.a    = 16'h0000;
        pif.b    = 16'h0000;
        pif.c_in = 1'b0;
        #2;
        check("reset.sum_q",   32'(pif.sum_q),   32'h0);
        check("reset.c_out_q", 32'(pif.c_out_q), 32'h0);
        check("reset.ovf_q",   32'(pif.ovf_q),   32'h0);
        @(posedge clk);
        #1;
        check("reset_hold.sum_q", 32'(pif.sum_q), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        apply("one_plus_one",  16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
        apply("wrap",          16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        apply("mixed_cin",     16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
        apply("alt_no_cin",    16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        apply("full_prop",     16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0);
        apply("zero_cin",      16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
        apply("pos_ovf",       16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        apply("neg_ovf",       16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        apply("neg_no_ovf",    16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);

        // Reset asserted between edges clears registers at once; combinational path is untouched.
        apply("pre_rst", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_async.sum_q",   32'(pif.sum_q),   32'h0);
        check("rst_async.c_out_q", 32'(pif.c_out_q), 32'h0);
        check("rst_async.ovf_q",   32'(pif.ovf_q),   32'h0);
        check("rst_async.sum",     32'(pif.sum),     32'h0);
        check("rst_async.c_out",   32'(pif.c_out),   32'h1);
        @(posedge clk);
        #1;
        check("rst_held.c_out_q",  32'(pif.c_out_q), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_release.c_out_q", 32'(pif.c_out_q), 32'h0);
        @(posedge clk);
        #1;
        check("rst_first_cap.c_out_q", 32'(pif.c_out_q), 32'h1);
        check("rst_first_cap.sum_q",   32'(pif.sum_q),   32'h0);

        // Group-boundary bits 3/4, 7/8, 11/12 plus sign bits and c_in, with full propagate elsewhere.
        for (int i = 0; i < 512; i++) begin
            ra = 16'($urandom);
            rb = ~ra;
            {ra[12], ra[11], ra[8], ra[7], ra[4], ra[3]} = 6'(i);
            ra[15] = i[6];
            rb[15] = i[7];
            apply_model("boundary", ra, rb, i[8]);
        end

        for (int i = 0; i < 1500; i++) begin
            apply_model("random", 16'($urandom), 16'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
